// File: rtl/uart_rx_fifo.sv
// Receive FIFO between a UART receiver and its consumer; first-word-fall-through head.
// Optional macro UART_RX_FIFO_ERR_DROP_EN: discard bytes flagged with a parity error.
module uart_rx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
) (
  input  logic                      clk,
  input  logic                      arstn,
  input  logic                      rx_done,
  input  logic [DATA_WIDTH-1:0]     rx_data,
  input  logic                      rx_error,
  input  logic                      rd_ready,
  input  logic                      clr_overflow,
  output logic                      rd_valid,
  output logic [DATA_WIDTH-1:0]     rd_data,
  output logic                      rd_error,
  output logic [$clog2(DEPTH):0]    level,
  output logic                      overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE  = (AW+1)'(1);

  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [DATA_WIDTH-1:0] data_mem [DEPTH];
  logic                  wr_req;
  logic                  wr_en;
  logic                  wr_reject;
  logic                  rd_fire;
  logic                  full;

  // Read side: an entry transfers on a cycle where rd_valid and rd_ready are both
  // high; rd_valid never depends on rd_ready, and rd_ready is ignored while rd_valid=0.
  assign rd_valid = (level != '0);
  assign rd_fire  = rd_valid & rd_ready;
  assign full     = (level == FULL);
  assign rd_data  = data_mem[rd_ptr];

`ifdef UART_RX_FIFO_ERR_DROP_EN
  assign wr_req   = rx_done & ~rx_error;
  assign rd_error = 1'b0;
`else
  logic err_mem [DEPTH];

  assign wr_req   = rx_done;
  assign rd_error = err_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_en) err_mem[wr_ptr] <= rx_error;
  end
`endif

  // A full FIFO still takes a byte when the head leaves in the same cycle.
  assign wr_en     = wr_req & (~full | rd_fire);
  assign wr_reject = wr_req & full & ~rd_fire;

  always_ff @(posedge clk) begin
    if (wr_en) data_mem[wr_ptr] <= rx_data;
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en)   wr_ptr <= wr_ptr + 1'b1;
      if (rd_fire) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_fire})
        2'b10:   level <= level + ONE;
        2'b01:   level <= level - ONE;
        default: level <= level;
      endcase
      // A lost byte in the same cycle as a clear keeps the flag set.
      if (wr_reject)         overflow <= 1'b1;
      else if (clr_overflow) overflow <= 1'b0;
    end
  end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: directed scenarios plus random traffic against a queue model.
module tb_uart_rx_fifo;
  localparam int DW    = 8;
  localparam int DEPTH = 16;
`ifdef UART_RX_FIFO_ERR_DROP_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          arstn;
  logic          rx_done, rx_error, rd_ready, clr_overflow;
  logic [DW-1:0] rx_data;
  logic          rd_valid, rd_error, overflow;
  logic [DW-1:0] rd_data;
  logic [4:0]    level;

  int checks = 0;
  int errors = 0;

  // reference model: expected entries in arrival order, occupancy, sticky flag
  logic [DW:0] exp_q[$];
  int          mdl_level = 0;
  bit          mdl_ovf   = 1'b0;

  uart_rx_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .arstn(arstn), .rx_done(rx_done), .rx_data(rx_data),
    .rx_error(rx_error), .rd_ready(rd_ready), .clr_overflow(clr_overflow),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_error(rd_error),
    .level(level), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: every read handshake must deliver the oldest expected entry
  always @(negedge clk) begin
    if (arstn === 1'b1 && rd_valid === 1'b1 && rd_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("read_from_empty_model", 32'(rd_valid), 32'd0);
      end else begin
        logic [DW:0] e;
        e = exp_q.pop_front();
        check("rd_data", 32'(rd_data), 32'(e[DW-1:0]));
        check("rd_error", 32'(rd_error), 32'(e[DW]));
      end
    end
  end

  // one clock of stimulus; state checked mid-cycle, model advanced at the edge
  task automatic cyc(input logic d, input logic [DW-1:0] dat, input logic e,
                     input logic r, input logic c);
    bit rd_fire, accept, reject;
    rx_done = d; rx_data = dat; rx_error = e; rd_ready = r; clr_overflow = c;
    @(negedge clk);
    check("level", 32'(level), 32'(mdl_level));
    check("rd_valid", 32'(rd_valid), 32'(mdl_level != 0));
    check("overflow", 32'(overflow), 32'(mdl_ovf));
    @(posedge clk);
    rd_fire = (mdl_level > 0) && r;
    accept  = 1'b0;
    reject  = 1'b0;
    if (d && !(DROP && e)) begin
      if (mdl_level < DEPTH || rd_fire) accept = 1'b1;
      else                              reject = 1'b1;
    end
    if (accept) exp_q.push_back({(DROP ? 1'b0 : e), dat});
    mdl_level = mdl_level + int'(accept) - int'(rd_fire);
    if (reject) mdl_ovf = 1'b1;
    else if (c) mdl_ovf = 1'b0;
    #1;
    rx_done = 1'b0; rd_ready = 1'b0; clr_overflow = 1'b0; rx_error = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
  endtask

  // asynchronous reset mid-cycle, with an rx_done held across it
  task automatic mid_reset();
    #2;
    arstn = 1'b0;
    rx_done = 1'b1; rx_data = 8'hEE;
    #1;
    check("rst_level", 32'(level), 32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    exp_q.delete();
    mdl_level = 0;
    mdl_ovf   = 1'b0;
    @(posedge clk);
    @(negedge clk);
    arstn = 1'b1;
    rx_done = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    arstn = 1'b0;
    rx_done = 1'b0; rx_data = '0; rx_error = 1'b0; rd_ready = 1'b0; clr_overflow = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_level", 32'(level), 32'd0);
    check("reset_rd_valid", 32'(rd_valid), 32'd0);
    check("reset_overflow", 32'(overflow), 32'd0);
    arstn = 1'b1;
    @(posedge clk);
    #1;

    // single byte in, one-cycle latency, then read out
    cyc(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
    idle(1);

    // fill, overflow, clear, full write+read, then drain in order
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, DW'(i), 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 8'h55, 1'b0, 1'b1, 1'b0);
    idle(1);
    drain(DEPTH + 1);

    // simultaneous read and write at level 1
    cyc(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 8'h22, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 8'h33, 1'b0, 1'b1, 1'b0);
    drain(2);

    // wrap-around with interleaved reads, level kept at most 3
    for (int i = 0; i < 40; i++)
      cyc(1'b1, DW'(i), 1'b0, (mdl_level >= 2) ? 1'b1 : 1'($urandom_range(0, 1)), 1'b0);
    drain(4);

    // error byte: stored with its flag, or dropped when the macro is set
    cyc(1'b1, 8'h3C, 1'b1, 1'b0, 1'b0);
    idle(1);
    drain(2);

    // overflow with coincident clear, then clear alone, then reset at level 5
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, DW'(8'h80 + i), 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 8'h99, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
    drain(DEPTH - 5);
    idle(1);
    mid_reset();
    idle(2);

    // random traffic
    for (int i = 0; i < 400; i++)
      cyc(1'($urandom_range(0, 99) < 55), DW'($urandom), 1'($urandom_range(0, 9) == 0),
          1'($urandom_range(0, 99) < 45), 1'($urandom_range(0, 19) == 0));
    drain(DEPTH + 2);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: byte width, matching the receiver's data width.
REQ-002 SHALL have parameter DEPTH, default 16: entry count; power of 2, at least 2.
REQ-003 SHALL have port clk  input  1  single clock, all logic on its rising edge.
REQ-004 SHALL have port arstn  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port rx_done  input  1  one-cycle pulse from the UART receiver: byte complete.
REQ-006 SHALL have port rx_data  input  DATA_WIDTH  received byte; valid while rx_done=1.
REQ-007 SHALL have port rx_error  input  1  parity error flag for the byte; valid while rx_done=1.
REQ-008 SHALL have port rd_ready  input  1  consumer accepts the head entry.
REQ-009 SHALL have port clr_overflow  input  1  clears the overflow flag.
REQ-010 SHALL have port rd_valid  output  1  head entry present (level != 0).
REQ-011 SHALL have port rd_data  output  DATA_WIDTH  head byte.
REQ-012 SHALL have port rd_error  output  1  head byte's stored error flag.
REQ-013 SHALL have port level  output  log2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-014 SHALL have port overflow  output  1  sticky flag: a byte was lost.

Function
REQ-015 SHALL perform a write on any cycle with rx_done=1 and an accepted write; the write stores {rx_error, rx_data} at wr_ptr.
REQ-016 SHALL accept a write when level<DEPTH, or when level==DEPTH and a read handshake occurs in the same cycle.
REQ-017 SHALL perform a read on the rd_valid&rd_ready handshake, which advances rd_ptr.
REQ-018 SHALL ignore rd_ready when rd_valid=0.
REQ-019 SHALL operate first-word-fall-through: rd_data and rd_error reflect mem[rd_ptr] combinationally from registered state.
REQ-020 SHALL have rd_data and rd_error as don't-care when rd_valid=0.
REQ-021 SHALL have a latency of one cycle: rx_done in cycle N gives rd_valid=1 in cycle N+1 when empty beforehand.
REQ-022 SHALL wrap wr_ptr and rd_ptr modulo DEPTH.
REQ-023 SHALL update level on the clock edge: +1 on write only, -1 on read only, unchanged on both or neither.
REQ-024 SHALL keep a simultaneous read and write at level 1 at level 1; the new byte becomes head in the next cycle.
REQ-025 SHALL set overflow on a rejected write (rx_done=1, level==DEPTH, no read handshake); the byte is discarded and FIFO contents are unchanged.
REQ-026 SHALL clear overflow with clr_overflow=1; set wins over clear in the same cycle.
REQ-027 SHALL hold state with no handshakes: all outputs are stable while rd_ready=0 and rx_done=0.

Reset
REQ-028 SHALL, on arstn low, asynchronously clear wr_ptr, rd_ptr, level and overflow, giving rd_valid=0, level=0, overflow=0.
REQ-029 SHALL NOT reset storage contents.
REQ-030 SHALL discard all entries on reset mid-operation, including an rx_done pulse coincident with reset.
REQ-031 SHALL resume operation on the first rising clk after arstn deasserts.

Configuration
REQ-032 SHALL support macro UART_RX_FIFO_ERR_DROP_EN.
REQ-033 SHALL, with UART_RX_FIFO_ERR_DROP_EN defined, not write bytes with rx_error=1, leave level unchanged, not set overflow, and tie rd_error to 0.
REQ-034 SHALL, with UART_RX_FIFO_ERR_DROP_EN undefined, store error bytes like any other byte and present the flag on rd_error.

Verification
REQ-035 SHALL verify single byte: reset, then rx_done with rx_data=0xA5, rx_error=0 -> next cycle rd_valid=1, rd_data=0xA5, level=1; rd_ready=1 for one cycle -> rd_valid=0, level=0.
REQ-036 SHALL verify fill/overflow at DEPTH=16: write 0x00..0x0F with rd_ready=0 -> level=16; write 0xFF -> overflow=1, level=16; then drain and read back 0x00..0x0F in order.
REQ-037 SHALL verify simultaneous operations: at full, rx_done with 0x55 plus a read handshake -> overflow stays 0, level=16, and 0x55 is read last; at level=1, simultaneous read and write -> level stays 1.
REQ-038 SHALL verify wrap-around: 40 bytes (0x00..0x27) with reads interleaved so level stays at most 3 -> all bytes received in order, no overflow.
REQ-039 SHALL verify error handling: rx_done with 0x3C, rx_error=1 -> macro undefined gives rd_valid=1, rd_error=1; macro defined gives level=0, rd_valid=0.
REQ-040 SHALL verify overflow clear and mid-operation reset: with overflow=1, clr_overflow=1 coincident with a rejected write -> overflow stays 1; then clr_overflow alone -> 0; arstn low at level=5 -> level=0, rd_valid=0, overflow=0 immediately.
